mux_stream_sel: RTL

//  Parametrised CHANNELS:1 mux of WIDTH-bit lanes with a registered output and a valid/ready output handshake.
//  Two modes: MANUAL, which re-samples a loaded channel, and SCAN, which visits channels 0..CHANNELS-1 round-robin, one per accepted beat.

---
 rtl/mux_stream_sel.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mux_stream_sel.sv
// CHANNELS:1 lane mux with MANUAL/SCAN selection; MUX_STREAM_PARITY_EN adds out_parity.
// One-edge capture into the output register; out_valid && !out_ready freezes the output and the scan pointer.
module mux_stream_sel #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      sel_load,
  input  logic                      scan_en,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      sel_err
`ifdef MUX_STREAM_PARITY_EN
  , output logic                    out_parity
`endif
);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  localparam logic [SEL_W:0]   CH_LIM   = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(CHANNELS - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_err_q, sel_err_d;

  logic             free;
  logic             in_range;
  logic             load_ok;
  logic             capture;
  logic [SEL_W-1:0] cap_sel;
  logic [WIDTH-1:0] ch [CHANNELS];
  logic [WIDTH-1:0] sample;

  assign free     = !out_valid_q || out_ready;
  assign in_range = {1'b0, sel_in} < CH_LIM;
  assign load_ok  = sel_load && in_range;

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      ch[k] = in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    capture = 1'b0;
    cap_sel = sel_q;
    case (state_q)
      IDLE: begin
        if (load_ok) begin
          sel_d   = sel_in;
          cap_sel = sel_in;
          capture = free;
          state_d = MANUAL;
        end else if (scan_en && !sel_load) begin
          sel_d   = '0;
          state_d = SCAN;
        end
      end
      MANUAL: begin
        capture = free;
        if (load_ok) begin
          sel_d   = sel_in;
          cap_sel = sel_in;
        end else if (scan_en && !sel_load) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
        capture = free;
        if (load_ok) begin
          sel_d   = sel_in;
          cap_sel = sel_in;
          state_d = MANUAL;
        end else if (sel_load) begin
          // rejected load: re-sample the current channel without stepping
          sel_d = sel_q;
        end else if (!scan_en) begin
          state_d = MANUAL;
        end else if (free) begin
          sel_d = (sel_q == LAST_SEL) ? '0 : sel_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sample = ch[cap_sel];

  always_comb begin
    out_data_d  = capture ? sample  : out_data_q;
    out_sel_d   = capture ? cap_sel : out_sel_q;
    out_valid_d = capture || (out_valid_q && !free);
    sel_err_d   = sel_load && !in_range;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;

`ifdef MUX_STREAM_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (capture) begin
      parity_q <= ^sample;
    end
  end

  assign out_parity = parity_q;
`endif

endmodule
